// File: rtl/ibex_ahbl_port_bridge.sv
// OBI-to-AHB-Lite master bridge for one Ibex memory port.
// Supports one outstanding transfer with a pipelined address/data phase.
// HWDATA is registered. Any naturally aligned byte-enable pattern maps to HSIZE/HADDR.
// The AHB two-cycle ERROR response is handled, and illegal writes complete with a local error.
module ibex_ahbl_port_bridge #(
    parameter int         AW        = 32,
    parameter int         DW        = 32,
    parameter logic [3:0] HPROT     = 4'b0011,
    parameter int         READ_ONLY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              gnt,
    input  logic              we,
    input  logic [DW/8-1:0]   be,
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     wdata,
    output logic              rvalid,
    output logic [DW-1:0]     rdata,
    output logic              err,
    output logic [AW-1:0]     haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [3:0]        hprot,
    output logic              hmastlock,
    output logic [DW-1:0]     hwdata,
    input  logic              hready,
    input  logic [DW-1:0]     hrdata,
    input  logic              hresp
);

    localparam int BW = DW / 8;
    localparam int BL = $clog2(BW);

    localparam logic [1:0] ST_IDLE = 2'd0;  // no data phase in flight
    localparam logic [1:0] ST_DATA = 2'd1;  // AHB data phase pending
    localparam logic [1:0] ST_ERR1 = 2'd2;  // first ERROR cycle seen
    localparam logic [1:0] ST_LERR = 2'd3;  // local error response pending

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] hwdata_q, hwdata_d;

    logic [BL-1:0] low_idx;
    logic          be_any;
    logic [BL:0]   be_cnt;
    logic [BW-1:0] be_shift;
    logic          be_contig, be_pow2, be_align, be_legal;
    logic [2:0]    size_pow;
    logic          local_err, issue_ok, ahb_accept;
    logic          unused_addr_lsb;

    // Find the lowest enabled lane and count the enabled lanes.
    always_comb begin
        low_idx = '0;
        be_any  = 1'b0;
        be_cnt  = '0;
        for (int i = BW - 1; i >= 0; i--) begin
            if (be[i]) begin
                low_idx = i[BL-1:0];
                be_any  = 1'b1;
                be_cnt  = be_cnt + (BL+1)'(1);
            end
        end
    end

    // A legal pattern is one contiguous power-of-two run, aligned to its own size.
    assign be_shift  = be >> low_idx;
    assign be_contig = ((be_shift + BW'(1)) & be_shift) == '0;
    assign be_pow2   = (be_cnt & (be_cnt - (BL+1)'(1))) == '0;
    assign be_align  = (low_idx & (be_cnt[BL-1:0] - BL'(1))) == '0;
    assign be_legal  = be_any & be_contig & be_pow2 & be_align;

    // log2 of the enabled-lane count for legal patterns.
    always_comb begin
        size_pow = 3'd0;
        for (int j = 0; j <= BL; j++) begin
            if (be_cnt == (BL+1)'(1 << j)) begin
                size_pow = 3'(j);
            end
        end
    end

    // Address-phase control: new requests only when no data phase is blocking.
    assign local_err  = we & ((READ_ONLY != 0) | ~be_legal);
    assign issue_ok   = hready & ((state_q == ST_IDLE) | ((state_q == ST_DATA) & ~hresp));
    assign gnt        = req & issue_ok;
    assign ahb_accept = gnt & ~local_err;
    assign htrans     = ahb_accept ? 2'b10 : 2'b00;
    assign hwrite     = ahb_accept & we & (READ_ONLY == 0);
    // Illegal read patterns fall back to a full-width access at the aligned word.
    assign haddr      = req ? {addr[AW-1:BL], (be_legal ? low_idx : {BL{1'b0}})} : '0;
    assign hsize      = req ? (be_legal ? size_pow : 3'(BL)) : 3'b000;

    assign hburst     = 3'b000;
    assign hprot      = HPROT;
    assign hmastlock  = 1'b0;
    assign hwdata     = hwdata_q;
    assign rdata      = hrdata;

    // The sub-word address comes from the byte enables, not from addr.
    assign unused_addr_lsb = ^addr[BL-1:0];

    // Response generation for the transfer currently in its data phase.
    always_comb begin
        rvalid = 1'b0;
        err    = 1'b0;
        case (state_q)
            ST_DATA: begin
                if (hready) begin
                    rvalid = 1'b1;
                    err    = hresp;
                end
            end
            ST_ERR1: begin
                if (hready) begin
                    rvalid = 1'b1;
                    err    = 1'b1;
                end
            end
            ST_LERR: begin
                rvalid = 1'b1;
                err    = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state selection; a grant in any state starts a new transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt) state_d = local_err ? ST_LERR : ST_DATA;
            end
            ST_DATA: begin
                if (hready) begin
                    if (gnt) state_d = local_err ? ST_LERR : ST_DATA;
                    else     state_d = ST_IDLE;
                end else if (hresp) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1: begin
                if (hready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write data is captured at the address phase and held through the data phase.
    assign hwdata_d = ahb_accept ? wdata : hwdata_q;

    // State and write-data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            hwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            hwdata_q <= hwdata_d;
        end
    end

endmodule

// File: tb/tb_ibex_ahbl_port_bridge.sv
// Bench for ibex_ahbl_port_bridge: a vector table, directed corner sequences and
// randomized traffic checked against a transaction-level reference.
module tb_ibex_ahbl_port_bridge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 32-bit port (shared inputs also feed the read-only instance)
    logic        req, we, hready, hresp;
    logic [3:0]  be;
    logic [31:0] addr, wdata, hrdata;
    logic        gnt, rvalid, err, hwrite, hmastlock;
    logic [31:0] rdata, haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    logic        ro_gnt, ro_rvalid, ro_err, ro_hwrite, ro_hmastlock;
    logic [31:0] ro_rdata, ro_haddr, ro_hwdata;
    logic [1:0]  ro_htrans;
    logic [2:0]  ro_hsize, ro_hburst;
    logic [3:0]  ro_hprot;

    // 64-bit port
    logic        w_req, w_we, w_hready, w_hresp;
    logic [7:0]  w_be;
    logic [31:0] w_addr;
    logic [63:0] w_wdata, w_hrdata;
    logic        w_gnt, w_rvalid, w_err, w_hwrite, w_hmastlock;
    logic [63:0] w_rdata, w_hwdata;
    logic [31:0] w_haddr;
    logic [1:0]  w_htrans;
    logic [2:0]  w_hsize, w_hburst;
    logic [3:0]  w_hprot;

    ibex_ahbl_port_bridge #(.AW(32), .DW(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .rvalid(rvalid), .rdata(rdata), .err(err), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hmastlock(hmastlock), .hwdata(hwdata), .hready(hready), .hrdata(hrdata), .hresp(hresp));

    ibex_ahbl_port_bridge #(.AW(32), .DW(32), .HPROT(4'b0010), .READ_ONLY(1)) u_dut_ro (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(ro_gnt), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .rvalid(ro_rvalid), .rdata(ro_rdata), .err(ro_err), .haddr(ro_haddr),
        .htrans(ro_htrans), .hwrite(ro_hwrite), .hsize(ro_hsize), .hburst(ro_hburst),
        .hprot(ro_hprot), .hmastlock(ro_hmastlock), .hwdata(ro_hwdata), .hready(hready),
        .hrdata(hrdata), .hresp(hresp));

    ibex_ahbl_port_bridge #(.AW(32), .DW(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .req(w_req), .gnt(w_gnt), .we(w_we), .be(w_be),
        .addr(w_addr), .wdata(w_wdata), .rvalid(w_rvalid), .rdata(w_rdata), .err(w_err),
        .haddr(w_haddr), .htrans(w_htrans), .hwrite(w_hwrite), .hsize(w_hsize),
        .hburst(w_hburst), .hprot(w_hprot), .hmastlock(w_hmastlock), .hwdata(w_hwdata),
        .hready(w_hready), .hrdata(w_hrdata), .hresp(w_hresp));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Reference size/address decode from the byte-enable rules, in plain arithmetic.
    function automatic void ref_decode(input int bw, input logic [7:0] b, input logic [31:0] a,
                                       output bit legal, output int sz, output logic [31:0] ha);
        int n;
        int low;
        int mask;
        n = 0;
        low = -1;
        for (int i = 0; i < bw; i++) begin
            if (b[i]) begin
                n++;
                if (low < 0) low = i;
            end
        end
        legal = 1'b0;
        if (n > 0 && (n & (n - 1)) == 0 && (low % n) == 0) begin
            mask  = ((1 << n) - 1) << low;
            legal = (int'(b) == mask);
        end
        sz = legal ? $clog2(n) : $clog2(bw);
        ha = (a / 32'(bw)) * 32'(bw) + 32'(legal ? low : 0);
    endfunction

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  exp_htrans;
        logic [2:0]  exp_hsize;
        logic [31:0] exp_haddr;
        logic        exp_err;
    } vec_t;

    typedef struct {
        bit          local_err;
        bit          err_seen;
        logic [31:0] wdata;
    } txn_t;

    vec_t tbl[11];
    txn_t pend[$];

    initial begin
        bit          legal, has, lerr, e_rv, e_er, pop, can, e_gnt;
        int          sz;
        logic [31:0] ha;
        logic [3:0]  pick[7];
        txn_t        t;

        tbl[0]  = '{1'b0, 4'b1100, 32'h1000_0006, 32'h0,        2'b10, 3'd1, 32'h1000_0006, 1'b0};
        tbl[1]  = '{1'b0, 4'b0001, 32'h0000_0020, 32'h0,        2'b10, 3'd0, 32'h0000_0020, 1'b0};
        tbl[2]  = '{1'b0, 4'b0010, 32'h0000_0023, 32'h0,        2'b10, 3'd0, 32'h0000_0021, 1'b0};
        tbl[3]  = '{1'b0, 4'b0110, 32'h0000_0040, 32'h0,        2'b10, 3'd2, 32'h0000_0040, 1'b0};
        tbl[4]  = '{1'b0, 4'b0000, 32'h0000_0047, 32'h0,        2'b10, 3'd2, 32'h0000_0044, 1'b0};
        tbl[5]  = '{1'b1, 4'b1111, 32'h0000_0050, 32'hCAFE_0001, 2'b10, 3'd2, 32'h0000_0050, 1'b0};
        tbl[6]  = '{1'b1, 4'b0110, 32'h0000_0060, 32'hCAFE_0002, 2'b00, 3'd0, 32'h0,         1'b1};
        tbl[7]  = '{1'b1, 4'b1000, 32'h0000_0013, 32'hCAFE_0003, 2'b10, 3'd0, 32'h0000_0013, 1'b0};
        tbl[8]  = '{1'b0, 4'b0111, 32'h0000_0000, 32'h0,        2'b10, 3'd2, 32'h0000_0000, 1'b0};
        tbl[9]  = '{1'b1, 4'b0101, 32'h0000_0070, 32'hCAFE_0004, 2'b00, 3'd0, 32'h0,         1'b1};
        tbl[10] = '{1'b1, 4'b0000, 32'h0000_0074, 32'hCAFE_0005, 2'b00, 3'd0, 32'h0,         1'b1};
        pick = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

        req = 0; we = 0; be = 0; addr = 0; wdata = 0; hready = 1; hresp = 0; hrdata = 0;
        w_req = 0; w_we = 0; w_be = 0; w_addr = 0; w_wdata = 0; w_hready = 1; w_hresp = 0;
        w_hrdata = 0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #3;
        chk("rst_gnt", gnt, 0);          chk("rst_htrans", htrans, 0);
        chk("rst_haddr", haddr, 0);      chk("rst_rvalid", rvalid, 0);
        chk("rst_err", err, 0);          chk("rst_hwdata", hwdata, 0);
        chk("rst_hburst", hburst, 0);    chk("rst_hprot", hprot, 4'b0011);
        chk("rst_hmastlock", hmastlock, 0);
        chk("rst_ro_hprot", ro_hprot, 4'b0010);
        chk("rst_w_hwdata", w_hwdata, 0); chk("rst_w_rvalid", w_rvalid, 0);
        $display("[TB] reset checked");
        rst_n = 1'b1;
        nxt();

        // ---------------- vector table (DW=32) ----------------
        hrdata = 32'hA5A5_1234;
        for (int i = 0; i < 11; i++) begin
            req = 1; we = tbl[i].we; be = tbl[i].be; addr = tbl[i].addr; wdata = tbl[i].wdata;
            hready = 1; hresp = 0;
            #2;
            chk("tbl_gnt", gnt, 1);
            chk("tbl_htrans", htrans, tbl[i].exp_htrans);
            chk("tbl_hwrite", hwrite, tbl[i].we && tbl[i].exp_htrans == 2'b10);
            if (tbl[i].exp_htrans == 2'b10) begin
                chk("tbl_hsize", hsize, tbl[i].exp_hsize);
                chk("tbl_haddr", haddr, tbl[i].exp_haddr);
            end
            nxt();
            req = 0;
            #2;
            chk("tbl_rvalid", rvalid, 1);
            chk("tbl_err", err, tbl[i].exp_err);
            if (!tbl[i].exp_err && !tbl[i].we) chk("tbl_rdata", rdata, 32'hA5A5_1234);
            if (!tbl[i].exp_err && tbl[i].we)  chk("tbl_hwdata", hwdata, tbl[i].wdata);
            $display("[TB] vec %0d we=%0b be=%b addr=%h haddr=%h hsize=%0d err=%0b",
                     i, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].exp_haddr,
                     tbl[i].exp_hsize, tbl[i].exp_err);
            nxt();
        end

        // ---------------- back-to-back writes ----------------
        req = 1; we = 1; be = 4'hF; addr = 32'h0; wdata = 32'h11;
        #2; chk("b2b_gnt0", gnt, 1); chk("b2b_haddr0", haddr, 32'h0); chk("b2b_htrans0", htrans, 2'b10);
        nxt();
        addr = 32'h4; wdata = 32'h22;
        #2; chk("b2b_gnt1", gnt, 1); chk("b2b_hwdata1", hwdata, 32'h11); chk("b2b_rvalid1", rvalid, 1);
        nxt();
        addr = 32'h8; wdata = 32'h33;
        #2; chk("b2b_gnt2", gnt, 1); chk("b2b_hwdata2", hwdata, 32'h22); chk("b2b_rvalid2", rvalid, 1);
        nxt();
        req = 0;
        #2; chk("b2b_hwdata3", hwdata, 32'h33); chk("b2b_rvalid3", rvalid, 1); chk("b2b_err3", err, 0);
        $display("[TB] back-to-back writes 0x11,0x22,0x33");
        nxt();

        // ---------------- wait states ----------------
        req = 1; we = 1; be = 4'hF; addr = 32'h100; wdata = 32'hDEAD_BEEF;
        #2; chk("ws_gnt", gnt, 1);
        nxt();
        we = 0; addr = 32'h104; wdata = 32'h0; hready = 0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("ws_gnt_hold", gnt, 0);
            chk("ws_hwdata", hwdata, 32'hDEAD_BEEF);
            chk("ws_rvalid", rvalid, 0);
            nxt();
        end
        hready = 1;
        #2; chk("ws_rvalid_end", rvalid, 1); chk("ws_err_end", err, 0); chk("ws_gnt_queued", gnt, 1);
        chk("ws_hwdata_end", hwdata, 32'hDEAD_BEEF);
        nxt();
        req = 0;
        #2; chk("ws_rd_rvalid", rvalid, 1); chk("ws_rd_hwdata", hwdata, 32'h0);
        $display("[TB] write 0xDEADBEEF with 3 wait states");
        nxt();

        // ---------------- AHB error response ----------------
        req = 1; we = 0; be = 4'hF; addr = 32'h200;
        #2; chk("ae_gnt", gnt, 1);
        nxt();
        addr = 32'h204; hresp = 1; hready = 0;
        #2; chk("ae1_htrans", htrans, 0); chk("ae1_gnt", gnt, 0); chk("ae1_rvalid", rvalid, 0);
        nxt();
        hready = 1;
        #2; chk("ae2_htrans", htrans, 0); chk("ae2_gnt", gnt, 0);
        chk("ae2_rvalid", rvalid, 1); chk("ae2_err", err, 1);
        nxt();
        hresp = 0;
        #2; chk("ae3_gnt", gnt, 1); chk("ae3_htrans", htrans, 2'b10); chk("ae3_rvalid", rvalid, 0);
        nxt();
        req = 0;
        #2; chk("ae4_rvalid", rvalid, 1); chk("ae4_err", err, 0);
        $display("[TB] AHB error response then queued read");
        nxt();
        nxt();
        nxt();

        // ---------------- read-only port ----------------
        req = 1; we = 1; be = 4'hF; addr = 32'h300; wdata = 32'h5555_AAAA;
        #2; chk("ro_gnt", ro_gnt, 1); chk("ro_htrans", ro_htrans, 0); chk("ro_hwrite", ro_hwrite, 0);
        nxt();
        req = 0;
        #2; chk("ro_rvalid", ro_rvalid, 1); chk("ro_err", ro_err, 1); chk("ro_htrans_resp", ro_htrans, 0);
        nxt();
        req = 1; we = 0;
        #2; chk("ro_rd_gnt", ro_gnt, 1); chk("ro_rd_htrans", ro_htrans, 2'b10);
        chk("ro_hprot", ro_hprot, 4'b0010);
        nxt();
        req = 0;
        #2; chk("ro_rd_rvalid", ro_rvalid, 1); chk("ro_rd_err", ro_err, 0);
        $display("[TB] read-only port: write rejected, read passed");
        nxt();
        nxt();

        // ---------------- DW=64 decode and reset mid-transfer ----------------
        w_req = 1; w_we = 0; w_be = 8'h3C; w_addr = 32'h10;
        #2; chk("w_ill_hsize", w_hsize, 3); chk("w_ill_haddr", w_haddr, 32'h10); chk("w_ill_gnt", w_gnt, 1);
        nxt();
        w_req = 1; w_be = 8'hF0; w_addr = 32'h8; w_wdata = 64'h0123_4567_89AB_CDEF;
        #2; chk("w_rvalid_prev", w_rvalid, 1);
        chk("w_gnt", w_gnt, 1); chk("w_haddr", w_haddr, 32'hC);
        chk("w_hsize", w_hsize, 2); chk("w_htrans", w_htrans, 2'b10);
        nxt();
        w_req = 0; w_hready = 0;
        #2; chk("w_hwdata_dp", w_hwdata, 64'h0123_4567_89AB_CDEF); chk("w_rvalid_dp", w_rvalid, 0);
        rst_n = 1'b0;
        w_hready = 1;
        #1; chk("w_rst_rvalid", w_rvalid, 0); chk("w_rst_htrans", w_htrans, 0);
        chk("w_rst_hwdata", w_hwdata, 0);
        nxt();
        rst_n = 1'b1;
        #2; chk("w_post_rvalid0", w_rvalid, 0);
        nxt();
        #2; chk("w_post_rvalid1", w_rvalid, 0);
        $display("[TB] DW=64 be=F0 @0x8 -> haddr 0xC, reset drops response");
        nxt();

        // ---------------- randomized traffic vs reference ----------------
        for (int c = 0; c < 600; c++) begin
            has = (pend.size() > 0);
            hresp = 0;
            hready = ($urandom_range(3) != 0);
            if (has && !pend[0].local_err) begin
                if (pend[0].err_seen) begin
                    hresp = 1;
                    hready = 1'($urandom_range(1));
                end else if ($urandom_range(7) == 0) begin
                    hresp = 1;
                    hready = 0;
                end
            end
            hrdata = $urandom;
            req    = ($urandom_range(3) != 0);
            we     = 1'($urandom_range(1));
            be     = ($urandom_range(1) == 0) ? pick[$urandom_range(6)] : 4'($urandom_range(15));
            addr   = $urandom;
            wdata  = $urandom;
            #2;
            ref_decode(4, {4'b0, be}, addr, legal, sz, ha);
            lerr = we && !legal;
            e_rv = 0; e_er = 0; pop = 0; can = hready;
            if (has) begin
                if (pend[0].local_err) begin
                    e_rv = 1; e_er = 1; pop = 1; can = 0;
                end else if (pend[0].err_seen) begin
                    can = 0;
                    if (hready) begin e_rv = 1; e_er = 1; pop = 1; end
                end else if (hresp) begin
                    can = 0;
                end else if (hready) begin
                    e_rv = 1; pop = 1;
                end
            end
            e_gnt = req && can;
            chk("rnd_gnt", gnt, e_gnt);
            chk("rnd_htrans", htrans, (e_gnt && !lerr) ? 2'b10 : 2'b00);
            chk("rnd_hwrite", hwrite, e_gnt && !lerr && we);
            chk("rnd_rvalid", rvalid, e_rv);
            chk("rnd_err", err, e_er);
            if (req) begin
                chk("rnd_haddr", haddr, ha);
                chk("rnd_hsize", hsize, 64'(sz));
            end
            if (e_rv && !e_er) chk("rnd_rdata", rdata, hrdata);
            if (has && !pend[0].local_err) chk("rnd_hwdata", hwdata, pend[0].wdata);
            if (e_rv) $display("[TB] rnd cyc %0d response err=%0b", c, e_er);
            if (has && !pend[0].local_err && !pend[0].err_seen && hresp && !hready)
                pend[0].err_seen = 1'b1;
            if (pop) void'(pend.pop_front());
            if (e_gnt) begin
                t.local_err = lerr;
                t.err_seen  = 1'b0;
                t.wdata     = wdata;
                pend.push_back(t);
            end
            nxt();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
